// File: rtl/clk_period_monitor.sv
// Multi-channel period/jitter meter: measures N rising-edge-to-rising-edge periods per
// synchronised input and reports last/min/max period, jitter, limit and timeout flags.
module clk_period_monitor #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned EDGE_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [EDGE_W-1:0]       n_periods,
    input  logic [CNT_W-1:0]        lim_lo,
    input  logic [CNT_W-1:0]        lim_hi,
    input  logic [NUM_CH-1:0]       sig_in,
    output logic                    busy,
    output logic                    done,
    output logic [NUM_CH*CNT_W-1:0] per_last,
    output logic [NUM_CH*CNT_W-1:0] per_min,
    output logic [NUM_CH*CNT_W-1:0] per_max,
    output logic [NUM_CH*CNT_W-1:0] jitter,
    output logic [NUM_CH-1:0]       out_of_range,
    output logic [NUM_CH-1:0]       timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic { G_IDLE, G_RUN } gstate_t;
    typedef enum logic [1:0] { C_IDLE, C_ARM, C_MEAS, C_FIN } cstate_t;

    gstate_t             gstate, gstate_nx;
    logic                accept;
    logic                fin_run;
    logic [NUM_CH-1:0]   fin;
    logic [EDGE_W-1:0]   n_q;
    logic [CNT_W-1:0]    lo_q, hi_q;

    // Start is refused while running and during the done cycle.
    assign accept  = start && (gstate == G_IDLE) && !done;
    assign fin_run = (gstate == G_RUN) && (&fin);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) gstate <= G_IDLE;
        else     gstate <= gstate_nx;
    end

    always_comb begin
        gstate_nx = gstate;
        case (gstate)
            G_IDLE:  if (accept)  gstate_nx = G_RUN;
            G_RUN:   if (fin_run) gstate_nx = G_IDLE;
            default: gstate_nx = G_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            n_q  <= '0;
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            done <= fin_run;
            if (accept) begin
                busy <= 1'b1;
                n_q  <= (n_periods == '0) ? EDGE_W'(1) : n_periods;
                lo_q <= lim_lo;
                hi_q <= lim_hi;
            end else if (fin_run) begin
                busy <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   prev_q;
        logic                   rise;
        logic                   sat;
        logic                   last_pc;
        cstate_t                cs, cs_nx;
        logic [CNT_W-1:0]       cnt, p_last, p_min, p_max, p_jit;
        logic [EDGE_W-1:0]      pcount;
        logic                   oor_q, to_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q <= '0;
                prev_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in[k]};
                prev_q <= sync_q[SYNC_STAGES-1];
            end
        end

        assign rise    = sync_q[SYNC_STAGES-1] & ~prev_q;
        // A coincident edge takes priority over saturation.
        assign sat     = (cnt == CNT_MAX) && !rise;
        assign last_pc = (pcount == (n_q - EDGE_W'(1)));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) cs <= C_IDLE;
            else     cs <= cs_nx;
        end

        always_comb begin
            cs_nx = cs;
            case (cs)
                C_IDLE: if (accept) cs_nx = C_ARM;
                C_ARM: begin
                    if (rise)     cs_nx = C_MEAS;
                    else if (sat) cs_nx = C_FIN;
                end
                C_MEAS: begin
                    if (rise && last_pc) cs_nx = C_FIN;
                    else if (sat)        cs_nx = C_FIN;
                end
                C_FIN:  if (fin_run) cs_nx = C_IDLE;
                default: cs_nx = C_IDLE;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt    <= '0;
                pcount <= '0;
                p_last <= '0;
                p_min  <= '0;
                p_max  <= '0;
                p_jit  <= '0;
                oor_q  <= 1'b0;
                to_q   <= 1'b0;
            end else if (accept) begin
                cnt    <= CNT_W'(1);
                pcount <= '0;
                p_last <= '0;
                p_min  <= CNT_MAX;
                p_max  <= '0;
                p_jit  <= '0;
                oor_q  <= 1'b0;
                to_q   <= 1'b0;
            end else begin
                case (cs)
                    C_ARM: begin
                        if (rise)     cnt  <= CNT_W'(1);
                        else if (sat) to_q <= 1'b1;
                        else          cnt  <= cnt + CNT_W'(1);
                    end
                    C_MEAS: begin
                        if (rise) begin
                            p_last <= cnt;
                            if (cnt < p_min) p_min <= cnt;
                            if (cnt > p_max) p_max <= cnt;
                            if ((cnt < lo_q) || (cnt > hi_q)) oor_q <= 1'b1;
                            cnt    <= CNT_W'(1);
                            pcount <= pcount + EDGE_W'(1);
                        end else if (sat) begin
                            to_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    C_FIN: begin
                        // Channels that never recorded a period report zero min/jitter.
                        if (fin_run) begin
                            if (pcount == '0) begin
                                p_min <= '0;
                                p_jit <= '0;
                            end else begin
                                p_jit <= p_max - p_min;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign fin[k]                       = (cs == C_FIN);
        assign per_last[k*CNT_W +: CNT_W]   = p_last;
        assign per_min[k*CNT_W +: CNT_W]    = p_min;
        assign per_max[k*CNT_W +: CNT_W]    = p_max;
        assign jitter[k*CNT_W +: CNT_W]     = p_jit;
        assign out_of_range[k]              = oor_q;
        assign timeout[k]                   = to_q;
    end

endmodule

// File: tb/tb_clk_period_monitor.sv
// Bench for clk_period_monitor: directed and random period patterns, results predicted
// from the period lists and checked by a done-triggered scoreboard monitor.
module tb_clk_period_monitor;

    localparam int unsigned NUM_CH      = 2;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned EDGE_W      = 8;
    localparam int unsigned SYNC_STAGES = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [EDGE_W-1:0]       n_periods;
    logic [CNT_W-1:0]        lim_lo, lim_hi;
    logic [NUM_CH-1:0]       sig_in;
    logic                    busy, done;
    logic [NUM_CH*CNT_W-1:0] per_last, per_min, per_max, jitter;
    logic [NUM_CH-1:0]       out_of_range, timeout;

    clk_period_monitor #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .EDGE_W(EDGE_W), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .n_periods(n_periods),
        .lim_lo(lim_lo), .lim_hi(lim_hi), .sig_in(sig_in), .busy(busy), .done(done),
        .per_last(per_last), .per_min(per_min), .per_max(per_max), .jitter(jitter),
        .out_of_range(out_of_range), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0][7:0] last, mn, mx, jit;
        logic [1:0]      oor, to;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   per_q[2][$];
    int   off[2];
    bit   hold_low[2];
    bit   extra[2];

    task automatic chk(input string name, input int ch, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s ch%0d: got %0d expected %0d", name, ch, got, exp);
        end
    endtask

    // Expected results straight from the list of periods each channel will see.
    function automatic exp_t model(input int lo, input int hi);
        exp_t e;
        e = '0;
        for (int k = 0; k < 2; k++) begin
            if (hold_low[k] || per_q[k].size() == 0) begin
                e.to[k] = 1'b1;
            end else begin
                int mn = 1 << 30;
                int mx = 0;
                foreach (per_q[k][i]) begin
                    int p = per_q[k][i];
                    e.last[k] = 8'(p);
                    if (p < mn) mn = p;
                    if (p > mx) mx = p;
                    if (p < lo || p > hi) e.oor[k] = 1'b1;
                end
                e.mn[k]  = 8'(mn);
                e.mx[k]  = 8'(mx);
                e.jit[k] = 8'(mx - mn);
            end
        end
        return e;
    endfunction

    always begin
        @(posedge clk);
        #1;
        if (done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                mon_e = sb_q.pop_front();
                for (int k = 0; k < 2; k++) begin
                    chk("per_last", k, per_last[k*CNT_W +: CNT_W], mon_e.last[k]);
                    chk("per_min",  k, per_min[k*CNT_W +: CNT_W],  mon_e.mn[k]);
                    chk("per_max",  k, per_max[k*CNT_W +: CNT_W],  mon_e.mx[k]);
                    chk("jitter",   k, jitter[k*CNT_W +: CNT_W],   mon_e.jit[k]);
                    chk("out_of_range", k, out_of_range[k], mon_e.oor[k]);
                    chk("timeout",  k, timeout[k], mon_e.to[k]);
                end
            end
        end
    end

    task automatic clr();
        for (int k = 0; k < 2; k++) begin
            per_q[k].delete();
            hold_low[k] = 1'b0;
            extra[k]    = 1'b0;
            off[k]      = 5;
        end
    endtask

    task automatic setp(input int k, input int a[4], input int cnt);
        per_q[k].delete();
        for (int i = 0; i < cnt; i++) per_q[k].push_back(a[i]);
    endtask

    task automatic check_all_zero();
        chk("rst_busy", 0, busy, 0);
        chk("rst_done", 0, done, 0);
        chk("rst_per_last", 0, per_last, 0);
        chk("rst_per_min", 0, per_min, 0);
        chk("rst_per_max", 0, per_max, 0);
        chk("rst_jitter", 0, jitter, 0);
        chk("rst_out_of_range", 0, out_of_range, 0);
        chk("rst_timeout", 0, timeout, 0);
    endtask

    task automatic run(input int n, input int lo, input int hi, input int abort_c,
                       input bit start_busy, input bit start_done);
        int rises[2][$];
        int last_req;
        int c;
        bit got_done;
        last_req = 0;
        for (int k = 0; k < 2; k++) begin
            int t;
            rises[k].delete();
            if (hold_low[k]) begin
                if (last_req < 255) last_req = 255;
            end else begin
                t = off[k];
                rises[k].push_back(t);
                foreach (per_q[k][i]) begin
                    t += per_q[k][i];
                    rises[k].push_back(t);
                end
                if (t > last_req) last_req = t;
                if (extra[k]) rises[k].push_back(t + 3);
            end
        end
        n_periods = EDGE_W'(n);
        lim_lo    = CNT_W'(lo);
        lim_hi    = CNT_W'(hi);
        start     = 1'b1;
        sb_q.push_back(model(lo, hi));
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", 0, busy, 1);
        c = 0;
        got_done = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                bit h = 1'b0;
                foreach (rises[k][i]) if (rises[k][i] == c) h = 1'b1;
                sig_in[k] = h;
            end
            if (start_busy && c == 5) begin
                start     = 1'b1;
                n_periods = EDGE_W'(1);
                lim_lo    = '0;
                lim_hi    = '0;
            end else begin
                start = 1'b0;
            end
            if (c == abort_c) begin
                rst = 1'b1;
                #1;
                check_all_zero();
                sb_q.delete();
                sig_in = '0;
                start  = 1'b0;
                @(posedge clk);
                #1;
                rst = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
            c++;
            if (!busy) begin
                got_done = 1'b1;
                break;
            end
        end
        start  = 1'b0;
        sig_in = '0;
        if (!got_done) begin
            chk("done_within_budget", 0, 0, 1);
            sb_q.delete();
        end else begin
            chk("done_with_busy_low", 0, done, 1);
            chk("done_after_last_edge", 0, (c > last_req) ? 1 : 0, 1);
            if (start_done) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            chk("done_one_cycle", 0, done, 0);
            chk("busy_stays_low", 0, busy, 0);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic case1(input int abort_c, input bit sb, input bit sd);
        clr();
        setp(0, '{10, 10, 10, 10}, 4);
        setp(1, '{7, 7, 7, 7}, 4);
        off[1] = 4;
        run(4, 5, 12, abort_c, sb, sd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; sig_in = '0; n_periods = '0; lim_lo = '0; lim_hi = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero();
        rst = 1'b0;
        @(posedge clk);
        #1;

        case1(-1, 1'b0, 1'b0);

        clr();
        setp(0, '{9, 11, 10, 12}, 4);
        setp(1, '{9, 11, 9, 11}, 4);
        run(4, 9, 11, -1, 1'b0, 1'b0);

        clr();
        setp(0, '{100, 100, 100, 100}, 4);
        hold_low[1] = 1'b1;
        run(4, 1, 200, -1, 1'b0, 1'b0);

        case1(30, 1'b0, 1'b0);
        case1(-1, 1'b0, 1'b0);

        case1(-1, 1'b1, 1'b1);

        clr();
        setp(0, '{13, 0, 0, 0}, 1);
        setp(1, '{6, 0, 0, 0}, 1);
        extra[0] = 1'b1;
        extra[1] = 1'b1;
        run(0, 7, 20, -1, 1'b0, 1'b0);

        clr();
        setp(0, '{255, 0, 0, 0}, 1);
        setp(1, '{254, 0, 0, 0}, 1);
        run(1, 0, 254, -1, 1'b0, 1'b0);

        for (int r = 0; r < 16; r++) begin
            int n, ne, lo, hi;
            clr();
            n  = int'($urandom_range(0, 6));
            ne = (n == 0) ? 1 : n;
            for (int k = 0; k < 2; k++) begin
                hold_low[k] = ($urandom_range(0, 7) == 0);
                extra[k]    = 1'($urandom_range(0, 1));
                off[k]      = int'($urandom_range(3, 20));
                if (!hold_low[k])
                    for (int i = 0; i < ne; i++) per_q[k].push_back(int'($urandom_range(2, 40)));
            end
            lo = int'($urandom_range(2, 20));
            hi = lo + int'($urandom_range(0, 25));
            run(n, lo, hi, -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", 0, sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
